// File: rtl/mem_responder.sv
// Memory-side responder: address register, word RAM and read-data register with programmable wait states.
// Define MEM_ADDR_CHECK_EN to add the sticky addr_err output for address loads with non-zero upper bits.
module mem_responder #(
    parameter int word_size   = 16,
    parameter int addr_size   = 8,
    parameter int wait_cycles = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_add_R,
    input  logic                 write,
    input  logic [word_size-1:0] bus_1,
    output logic [word_size-1:0] mem_word,
`ifdef MEM_ADDR_CHECK_EN
    output logic                 addr_err,
`endif
    output logic                 ready
);

    localparam int         DEPTH     = 1 << addr_size;
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] RD_BUSY   = 2'd1;
    localparam logic [1:0] WR_BUSY   = 2'd2;
    localparam logic [3:0] WAIT_INIT = 4'(wait_cycles);

    logic [1:0]           state_r, state_s;
    logic [3:0]           cnt_r, cnt_s;
    logic [addr_size-1:0] addr_r;
    logic [addr_size-1:0] bus_addr_s;
    logic [word_size-1:0] wdata_r, wdata_s;
    logic [word_size-1:0] mem_word_r, mem_word_s;
    logic                 ready_r, ready_s;
    logic                 addr_load_s;
    logic                 ram_we_s;
    logic [word_size-1:0] ram [DEPTH];

    assign bus_addr_s = bus_1[addr_size-1:0];
    assign mem_word   = mem_word_r;
    assign ready      = ready_r;

    // Next-state logic; a finishing access (cnt==0) takes priority over any request in that cycle.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        wdata_s     = wdata_r;
        mem_word_s  = mem_word_r;
        ready_s     = ready_r;
        addr_load_s = 1'b0;
        ram_we_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (write) begin
                    addr_load_s = load_add_R;
                    wdata_s     = bus_1;
                    cnt_s       = WAIT_INIT;
                    ready_s     = 1'b0;
                    state_s     = WR_BUSY;
                end else if (load_add_R) begin
                    addr_load_s = 1'b1;
                    cnt_s       = WAIT_INIT;
                    ready_s     = 1'b0;
                    state_s     = RD_BUSY;
                end else begin
                    ready_s = 1'b1;
                end
            end
            RD_BUSY: begin
                if (cnt_r == 4'd0) begin
                    mem_word_s = ram[addr_r];
                    ready_s    = 1'b1;
                    state_s    = IDLE;
                end else if (write) begin
                    // Load-address-then-write: the pending read is dropped in favour of the write.
                    addr_load_s = load_add_R;
                    wdata_s     = bus_1;
                    cnt_s       = WAIT_INIT;
                    state_s     = WR_BUSY;
                end else if (load_add_R) begin
                    addr_load_s = 1'b1;
                    cnt_s       = WAIT_INIT;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            WR_BUSY: begin
                if (cnt_r == 4'd0) begin
                    ram_we_s = 1'b1;
                    ready_s  = 1'b1;
                    state_s  = IDLE;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                ready_s = 1'b1;
                state_s = IDLE;
            end
        endcase
    end

    // Control and data registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            addr_r     <= {addr_size{1'b0}};
            wdata_r    <= {word_size{1'b0}};
            mem_word_r <= {word_size{1'b0}};
            ready_r    <= 1'b1;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            wdata_r    <= wdata_s;
            mem_word_r <= mem_word_s;
            ready_r    <= ready_s;
            if (addr_load_s) begin
                addr_r <= bus_addr_s;
            end else begin
                addr_r <= addr_r;
            end
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram[addr_r] <= wdata_r;
        end
    end

`ifdef MEM_ADDR_CHECK_EN
    logic upper_nz_s;
    logic addr_err_r;

    assign upper_nz_s = (bus_1[word_size-1:addr_size] != {(word_size-addr_size){1'b0}});
    assign addr_err   = addr_err_r;

    // Sticky flag for address loads that had bits above the RAM range.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_err_r <= 1'b0;
        end else if (addr_load_s && upper_nz_s) begin
            addr_err_r <= 1'b1;
        end else begin
            addr_err_r <= addr_err_r;
        end
    end
`else
    logic unused_upper_s;
    assign unused_upper_s = |bus_1[word_size-1:addr_size];
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized traffic against a RAM model.
`timescale 1ns/1ps
module tb_mem_responder;
    localparam int WC = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_add_R = 1'b0, write = 1'b0;
    logic [15:0] bus_1 = 16'h0000;
    logic [15:0] mem_word;
    logic        ready;
    logic        ld0 = 1'b0, wr0 = 1'b0;
    logic [15:0] bus0 = 16'h0000;
    logic [15:0] mw0;
    logic        rdy0;
`ifdef MEM_ADDR_CHECK_EN
    logic        addr_err, addr_err0;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] m_ram [256];
    bit          m_known [256];
    logic [15:0] m_word = 16'h0000;
    bit          m_word_known = 1'b1;

    mem_responder #(.word_size(16), .addr_size(8), .wait_cycles(WC)) dut (
        .clk(clk), .rst(rst), .load_add_R(load_add_R), .write(write), .bus_1(bus_1),
`ifdef MEM_ADDR_CHECK_EN
        .addr_err(addr_err),
`endif
        .mem_word(mem_word), .ready(ready));

    mem_responder #(.word_size(16), .addr_size(8), .wait_cycles(0)) dut0 (
        .clk(clk), .rst(rst), .load_add_R(ld0), .write(wr0), .bus_1(bus0),
`ifdef MEM_ADDR_CHECK_EN
        .addr_err(addr_err0),
`endif
        .mem_word(mw0), .ready(rdy0));

    always #5 clk = ~clk;

    function automatic int wrap(input logic [15:0] a);
        return int'(a) % 256;
    endfunction

    // One request cycle, then count edges after acceptance until ready returns.
    task automatic req(input logic ld, input logic wr, input logic [15:0] d, output int edges);
        @(negedge clk);
        load_add_R = ld; write = wr; bus_1 = d;
        @(posedge clk); #1;
        load_add_R = 1'b0; write = 1'b0;
        edges = 0;
        while (ready !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic do_read(input logic [15:0] a, output int edges);
        req(1'b1, 1'b0, a, edges);
        m_word = m_ram[wrap(a)];
        m_word_known = m_known[wrap(a)];
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, output int edges);
        int e0;
        do_read(a, e0);
        req(1'b0, 1'b1, d, edges);
        m_ram[wrap(a)] = d;
        m_known[wrap(a)] = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (mem_word !== 16'h0000) begin errors++; $display("FAIL reset_mem_word got=%h exp=0000", mem_word); end
        checks++; if (rdy0 !== 1'b1 || mw0 !== 16'h0000) begin errors++; $display("FAIL reset_dut0 got=%b/%h exp=1/0000", rdy0, mw0); end
`ifdef MEM_ADDR_CHECK_EN
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err got=%b exp=0", addr_err); end
`endif
        rst = 1'b1;
        m_word = 16'h0000; m_word_known = 1'b1;
    endtask

    task automatic test_read_then_write;
        int e;
        @(negedge clk);
        load_add_R = 1'b1; bus_1 = 16'h0003;
        @(posedge clk); #1;
        load_add_R = 1'b0; write = 1'b1; bus_1 = 16'h1234;
        @(posedge clk); #1;
        write = 1'b0;
        e = 0;
        while (ready !== 1'b1 && e < 40) begin @(posedge clk); #1; e++; end
        m_ram[3] = 16'h1234; m_known[3] = 1'b1;
        checks++; if (e !== WC + 1) begin errors++; $display("FAIL cancel_write_wait got=%0d exp=%0d", e, WC + 1); end
        checks++; if (mem_word !== m_word) begin errors++; $display("FAIL cancel_mem_word got=%h exp=%h", mem_word, m_word); end
        do_read(16'h0003, e);
        checks++; if (e !== WC + 1) begin errors++; $display("FAIL read3_wait got=%0d exp=%0d", e, WC + 1); end
        checks++; if (mem_word !== 16'h1234) begin errors++; $display("FAIL read3_data got=%h exp=1234", mem_word); end
    endtask

    task automatic test_both_same_edge;
        int e;
        req(1'b1, 1'b1, 16'h0007, e);
        m_ram[7] = 16'h0007; m_known[7] = 1'b1;
        checks++; if (e !== WC + 1) begin errors++; $display("FAIL both_wait got=%0d exp=%0d", e, WC + 1); end
        checks++; if (mem_word !== m_word) begin errors++; $display("FAIL both_mem_word got=%h exp=%h", mem_word, m_word); end
        do_read(16'h0007, e);
        checks++; if (mem_word !== 16'h0007) begin errors++; $display("FAIL both_read got=%h exp=0007", mem_word); end
    endtask

    task automatic test_busy_reject;
        int e;
        logic [15:0] a, b, d, db;
        a = 16'h0040 + 16'($urandom_range(0, 15));
        b = 16'h0080 + 16'($urandom_range(0, 15));
        d = 16'($urandom); db = ~d;
        do_write(b, db, e);
        do_read(a, e);
        @(negedge clk); write = 1'b1; bus_1 = d;
        @(posedge clk); #1; write = 1'b0; load_add_R = 1'b1; bus_1 = b;
        @(posedge clk); #1; load_add_R = 1'b0;
        e = 0;
        while (ready !== 1'b1 && e < 40) begin @(posedge clk); #1; e++; end
        m_ram[wrap(a)] = d; m_known[wrap(a)] = 1'b1;
        do_read(a, e);
        checks++; if (mem_word !== d) begin errors++; $display("FAIL busy_orig_addr got=%h exp=%h", mem_word, d); end
        do_read(b, e);
        checks++; if (mem_word !== db) begin errors++; $display("FAIL busy_other_addr got=%h exp=%h", mem_word, db); end
    endtask

    task automatic test_completion_reject;
        int e;
        logic [15:0] a;
        a = 16'h0040;
        do_write(a, 16'h5A5A, e);
        @(negedge clk); load_add_R = 1'b1; bus_1 = a;
        @(posedge clk); #1; load_add_R = 1'b0;
        repeat (WC) @(posedge clk);
        #1; write = 1'b1; bus_1 = 16'hDEAD;
        @(posedge clk); #1; write = 1'b0;
        checks++; if (ready !== 1'b1 || mem_word !== 16'h5A5A) begin errors++; $display("FAIL complete_edge got=%b/%h exp=1/5a5a", ready, mem_word); end
        @(posedge clk); #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL complete_reject_ready got=%b exp=1", ready); end
        do_read(a, e);
        checks++; if (mem_word !== 16'h5A5A) begin errors++; $display("FAIL complete_reject_ram got=%h exp=5a5a", mem_word); end
    endtask

    task automatic test_restart;
        int e;
        do_write(16'h0011, 16'h1111, e);
        do_write(16'h0022, 16'h2222, e);
        @(negedge clk); load_add_R = 1'b1; bus_1 = 16'h0011;
        @(posedge clk); #1; bus_1 = 16'h0022;
        @(posedge clk); #1; load_add_R = 1'b0;
        e = 1;
        while (ready !== 1'b1 && e < 40) begin @(posedge clk); #1; e++; end
        checks++; if (e !== WC + 2) begin errors++; $display("FAIL restart_wait got=%0d exp=%0d", e, WC + 2); end
        checks++; if (mem_word !== 16'h2222) begin errors++; $display("FAIL restart_data got=%h exp=2222", mem_word); end
`ifdef MEM_ADDR_CHECK_EN
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL addr_err_early got=%b exp=0", addr_err); end
`endif
    endtask

    task automatic test_random;
        int e;
        logic [15:0] a, d;
        for (int i = 0; i < 16; i++) begin
            do_write(16'(i), 16'($urandom), e);
        end
        for (int i = 0; i < 30; i++) begin
            a = 16'(($urandom_range(0, 255) << 8) | $urandom_range(0, 15));
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                do_read(a, e);
            end else begin
                do_write(a, d, e);
            end
            checks++; if (e !== WC + 1) begin errors++; $display("FAIL rand_wait op=%0d got=%0d exp=%0d", i, e, WC + 1); end
            if (m_word_known) begin
                checks++; if (mem_word !== m_word) begin errors++; $display("FAIL rand_mem_word op=%0d got=%h exp=%h", i, mem_word, m_word); end
            end
        end
    endtask

    task automatic test_wrap;
        int e;
        logic [15:0] d;
        d = 16'($urandom);
        do_write(16'h0102, d, e);
        do_read(16'h0002, e);
        checks++; if (mem_word !== d) begin errors++; $display("FAIL wrap_data got=%h exp=%h", mem_word, d); end
`ifdef MEM_ADDR_CHECK_EN
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL wrap_addr_err got=%b exp=1", addr_err); end
        do_read(16'h0010, e);
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL addr_err_sticky got=%b exp=1", addr_err); end
`endif
    endtask

    task automatic test_reset_mid_write;
        int e;
        do_write(16'h0005, 16'h1111, e);
        @(negedge clk); write = 1'b1; bus_1 = 16'hBEEF;
        @(posedge clk); #1; write = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++; if (ready !== 1'b1 || mem_word !== 16'h0000) begin errors++; $display("FAIL rst_mid_write got=%b/%h exp=1/0000", ready, mem_word); end
`ifdef MEM_ADDR_CHECK_EN
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL rst_addr_err got=%b exp=0", addr_err); end
`endif
        @(negedge clk); rst = 1'b1;
        m_word = 16'h0000;
        do_read(16'h0005, e);
        checks++; if (mem_word !== 16'h1111) begin errors++; $display("FAIL rst_write_discard got=%h exp=1111", mem_word); end
    endtask

    task automatic test_wait0;
        logic [15:0] d;
        d = 16'($urandom);
        @(negedge clk); ld0 = 1'b1; bus0 = 16'h0003;
        @(posedge clk); #1; ld0 = 1'b0;
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL w0_accept got=%b exp=0", rdy0); end
        @(posedge clk); #1;
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL w0_rd_done got=%b exp=1", rdy0); end
        @(negedge clk); wr0 = 1'b1; bus0 = d;
        @(posedge clk); #1; wr0 = 1'b0;
        @(posedge clk); #1;
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL w0_wr_done got=%b exp=1", rdy0); end
        @(negedge clk); ld0 = 1'b1; bus0 = 16'h0003;
        @(posedge clk); #1; ld0 = 1'b0;
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL w0_busy got=%b exp=0", rdy0); end
        @(posedge clk); #1;
        checks++; if (rdy0 !== 1'b1 || mw0 !== d) begin errors++; $display("FAIL w0_read got=%b/%h exp=1/%h", rdy0, mw0, d); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin m_ram[i] = 16'h0000; m_known[i] = 1'b0; end
        #3;
        test_reset;
        test_read_then_write;
        test_both_same_edge;
        test_busy_reject;
        test_completion_reject;
        test_restart;
        test_random;
        test_wrap;
        test_reset_mid_write;
        test_wait0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
